placement_req_scheduler: RTL and testbench
==========================================

Name: placement_req_scheduler

Overview:
- Front-end sequencer for the rectangle placement engine (height_i/width_i in; index_x_o/index_y_o/strike_o out; one placement per 4-cycle slot).
- Arbitrates two requesters round-robin onto the engine's fixed slot cadence and drives the engine inputs for a full slot.
- Tracks in-flight requests with a tag pipeline and returns each engine result to its owner as a one-cycle response carrying error and strike flags.

Parameters:
SLOT_CYCLES, 4, cycles per engine input slot; engine inputs held this long.
RESULT_LAT, 8, cycles from first cycle of an issued slot to the cycle the engine result is sampled; must be a multiple of SLOT_CYCLES.
DIM_W, 5, height/width width.
IDX_W, 8, index width.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req0_valid_i  in  1  requester 0 has a rectangle
req0_height_i  in  DIM_W  requester 0 height
req0_width_i  in  DIM_W  requester 0 width
req0_ready_o  out  1  requester 0 accepted this cycle when valid&ready
req1_valid_i / req1_height_i / req1_width_i / req1_ready_o  same as requester 0, for requester 1
eng_height_o  out  DIM_W  to engine height_i
eng_width_o  out  DIM_W  to engine width_i
eng_index_x_i  in  IDX_W  from engine index_x_o
eng_index_y_i  in  IDX_W  from engine index_y_o
eng_strike_i  in  4  from engine strike_o (cumulative count)
rsp_valid_o  out  1  one-cycle response pulse
rsp_id_o  out  1  owning requester
rsp_index_x_o  out  IDX_W  placed x
rsp_index_y_o  out  IDX_W  placed y
rsp_err_o  out  1  request had zero height or width
rsp_strike_o  out  1  engine strike count rose for this request
busy_o  out  1  any request in flight

Behaviour:
- Reset (async, rst_i=1): every output 0, slot_cnt=0, tag pipeline cleared, last_grant=1, strike_prev=0. In-flight requests are discarded; no response is ever produced for them.
- slot_cnt counts 0..SLOT_CYCLES-1, wrapping, and increments every cycle after reset release. The ready window is slot_cnt==SLOT_CYCLES-1.
- Arbitration is combinational in the ready window only:
  - Both valid: grant the requester other than last_grant.
  - One valid: grant it.
  - reqN_ready_o=1 only in the window for the granted requester; 0 in all other cycles.
  - last_grant updates only on a handshake.
- Issue (registered, next cycle, slot_cnt==0):
  - Handshake with nonzero dimensions: eng_height_o/eng_width_o take the accepted values and hold for SLOT_CYCLES cycles.
  - No handshake, or height==0 or width==0: drive 0/0 for the slot. A zero-dimension request is still consumed.
- Tag pipeline: RESULT_LAT/SLOT_CYCLES entries of {valid,id,err}. It shifts at each slot_cnt==0. The new entry is {handshake, granted id, zero-dim}.
- Result sample at slot_cnt==0: the entry leaving the pipeline belongs to the slot issued RESULT_LAT cycles earlier. If that entry is valid, then next cycle:
  - rsp_valid_o=1 for exactly one cycle, with rsp_id_o=id and rsp_err_o=err.
  - err=1: rsp_index_x_o/rsp_index_y_o=all ones and rsp_strike_o=0.
  - err=0: index outputs take eng_index_x_i/eng_index_y_i, and rsp_strike_o=(eng_strike_i!=strike_prev).
  - strike_prev<=eng_strike_i on every valid non-err sample.
- rsp_* data holds its last value when rsp_valid_o=0.
- Latency: handshake at cycle H → engine inputs H+1..H+SLOT_CYCLES → sample H+1+RESULT_LAT → rsp_valid_o at H+2+RESULT_LAT (H+10 at defaults).
- Throughput: at most one request per slot. Sustained alternation when both requesters hold valid.
- busy_o=1 while any pipeline entry is valid or an issued slot is active.
- A valid dropped before the ready window is not a handshake; the slot is idle.

Test Plan:
1. req0 valid h=3,w=4 from reset → req0_ready_o=1 at slot_cnt 3 (cycle 4 after release); eng 3/4 for cycles 5-8, then 0/0; engine model returns x=0,y=0 → rsp_valid_o at handshake+10, id=0, err=0, strike=0.
2. Both requesters valid continuously → grants 0,1,0,1 on successive windows; responses every 4 cycles with ids 0,1,0,1, each matching the corresponding engine result.
3. req1 h=5,w=0 → consumed; eng stays 0/0; rsp at +10 with id=1, err=1, x=y=255.
4. Two requests where the engine model steps eng_strike_i 0→1 on the second → rsp_strike_o=0 then 1; a third request with strike steady at 1 → rsp_strike_o=0.
5. Two requests in flight, rst_i pulsed mid-slot → all outputs 0 immediately (asynchronous); after release no rsp_valid_o until a new handshake; slot_cnt restarts at 0.
6. req0 valid deasserted at slot_cnt 2 → no ready, idle slot drives 0/0, no response, busy_o stays 0.

Source files
------------

// File: rtl/placement_req_scheduler.sv
// Front-end sequencer for the rectangle placement engine: round-robin arbitration
// of two requesters onto the fixed slot cadence, with tagged result return.
module placement_req_scheduler #(
    parameter int SLOT_CYCLES = 4,
    parameter int RESULT_LAT  = 8,
    parameter int DIM_W       = 5,
    parameter int IDX_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic [DIM_W-1:0] req0_height_i,
    input  logic [DIM_W-1:0] req0_width_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [DIM_W-1:0] req1_height_i,
    input  logic [DIM_W-1:0] req1_width_i,
    output logic             req1_ready_o,
    output logic [DIM_W-1:0] eng_height_o,
    output logic [DIM_W-1:0] eng_width_o,
    input  logic [IDX_W-1:0] eng_index_x_i,
    input  logic [IDX_W-1:0] eng_index_y_i,
    input  logic [3:0]       eng_strike_i,
    output logic             rsp_valid_o,
    output logic             rsp_id_o,
    output logic [IDX_W-1:0] rsp_index_x_o,
    output logic [IDX_W-1:0] rsp_index_y_o,
    output logic             rsp_err_o,
    output logic             rsp_strike_o,
    output logic             busy_o
);
    localparam int DEPTH = RESULT_LAT / SLOT_CYCLES;
    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOT_CYCLES - 1);

    typedef struct packed {
        logic valid;
        logic id;
        logic err;
    } tag_t;

    logic [CNT_W-1:0] slot_cnt;
    logic             last_grant;
    logic [3:0]       strike_prev;
    tag_t             issue_tag;
    tag_t             pipe [DEPTH];
    tag_t             leaving;

    logic             window;
    logic             slot_start;
    logic             handshake;
    logic             grant_id;
    logic [DIM_W-1:0] grant_h;
    logic [DIM_W-1:0] grant_w;
    logic             zero_dim;
    logic             any_valid;

    always_comb begin
        window       = (slot_cnt == LAST_SLOT);
        slot_start   = (slot_cnt == '0);
        grant_id     = (req0_valid_i && req1_valid_i) ? ~last_grant : req1_valid_i;
        handshake    = window && (req0_valid_i || req1_valid_i);
        req0_ready_o = handshake && !grant_id;
        req1_ready_o = handshake && grant_id;
        grant_h      = grant_id ? req1_height_i : req0_height_i;
        grant_w      = grant_id ? req1_width_i  : req0_width_i;
        zero_dim     = (grant_h == '0) || (grant_w == '0);
        leaving      = pipe[DEPTH-1];
        any_valid    = issue_tag.valid;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            any_valid = any_valid || pipe[i].valid;
        end
        busy_o       = any_valid;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_cnt <= '0;
        end else if (window) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    // Issue register: the tag for the slot being driven lives here until the
    // first cycle of that slot pushes it into the result pipeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eng_height_o <= '0;
            eng_width_o  <= '0;
            issue_tag    <= '0;
            last_grant   <= 1'b1;
        end else if (window) begin
            eng_height_o <= (handshake && !zero_dim) ? grant_h : '0;
            eng_width_o  <= (handshake && !zero_dim) ? grant_w : '0;
            issue_tag    <= '{valid: handshake, id: grant_id, err: zero_dim};
            if (handshake) begin
                last_grant <= grant_id;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else if (slot_start) begin
            pipe[0] <= issue_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_o   <= 1'b0;
            rsp_id_o      <= 1'b0;
            rsp_index_x_o <= '0;
            rsp_index_y_o <= '0;
            rsp_err_o     <= 1'b0;
            rsp_strike_o  <= 1'b0;
            strike_prev   <= '0;
        end else begin
            rsp_valid_o <= slot_start && leaving.valid;
            if (slot_start && leaving.valid) begin
                rsp_id_o  <= leaving.id;
                rsp_err_o <= leaving.err;
                if (leaving.err) begin
                    rsp_index_x_o <= '1;
                    rsp_index_y_o <= '1;
                    rsp_strike_o  <= 1'b0;
                end else begin
                    rsp_index_x_o <= eng_index_x_i;
                    rsp_index_y_o <= eng_index_y_i;
                    rsp_strike_o  <= (eng_strike_i != strike_prev);
                    strike_prev   <= eng_strike_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_placement_req_scheduler.sv
// Scoreboard bench for placement_req_scheduler with a small engine model:
// x = width, y = height + 100, strike count bumps for height >= 16.
module tb_placement_req_scheduler;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       req0_valid_i = 1'b0;
    logic [4:0] req0_height_i = '0;
    logic [4:0] req0_width_i = '0;
    logic       req0_ready_o;
    logic       req1_valid_i = 1'b0;
    logic [4:0] req1_height_i = '0;
    logic [4:0] req1_width_i = '0;
    logic       req1_ready_o;
    logic [4:0] eng_height_o;
    logic [4:0] eng_width_o;
    logic [7:0] eng_index_x_i;
    logic [7:0] eng_index_y_i;
    logic [3:0] eng_strike_i;
    logic       rsp_valid_o;
    logic       rsp_id_o;
    logic [7:0] rsp_index_x_o;
    logic [7:0] rsp_index_y_o;
    logic       rsp_err_o;
    logic       rsp_strike_o;
    logic       busy_o;

    placement_req_scheduler #(
        .SLOT_CYCLES(4),
        .RESULT_LAT (8),
        .DIM_W      (5),
        .IDX_W      (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req0_valid_i  (req0_valid_i),
        .req0_height_i (req0_height_i),
        .req0_width_i  (req0_width_i),
        .req0_ready_o  (req0_ready_o),
        .req1_valid_i  (req1_valid_i),
        .req1_height_i (req1_height_i),
        .req1_width_i  (req1_width_i),
        .req1_ready_o  (req1_ready_o),
        .eng_height_o  (eng_height_o),
        .eng_width_o   (eng_width_o),
        .eng_index_x_i (eng_index_x_i),
        .eng_index_y_i (eng_index_y_i),
        .eng_strike_i  (eng_strike_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_id_o      (rsp_id_o),
        .rsp_index_x_o (rsp_index_x_o),
        .rsp_index_y_o (rsp_index_y_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_strike_o  (rsp_strike_o),
        .busy_o        (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Engine model: latches inputs on the first cycle of each slot and presents
    // that slot's result two slots later.
    int unsigned phase;
    logic [4:0]  ea_h, ea_w, eb_h, eb_w;
    logic [3:0]  strike_acc;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase <= 0; ea_h <= '0; ea_w <= '0; eb_h <= '0; eb_w <= '0; strike_acc <= '0;
        end else begin
            phase <= (phase == 3) ? 0 : phase + 1;
            if (phase == 0) begin
                ea_h <= eng_height_o;
                ea_w <= eng_width_o;
                eb_h <= ea_h;
                eb_w <= ea_w;
                if (ea_h >= 5'd16) strike_acc <= strike_acc + 4'd1;
            end
        end
    end
    assign eng_index_x_i = {3'b000, eb_w};
    assign eng_index_y_i = {3'b000, eb_h} + 8'd100;
    assign eng_strike_i  = strike_acc;

    typedef struct {
        bit         id;
        bit         err;
        logic [7:0] x;
        logic [7:0] y;
        bit         strike;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   grant_q[$];
    int   hcyc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rel_cyc;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic exp_t mk_exp(bit id, logic [4:0] h, logic [4:0] w, int hc);
        exp_t e;
        e.id  = id;
        e.err = (h == 5'd0) || (w == 5'd0);
        if (e.err) begin
            e.x = 8'hFF; e.y = 8'hFF; e.strike = 1'b0;
        end else begin
            e.x = {3'b000, w}; e.y = {3'b000, h} + 8'd100; e.strike = (h >= 5'd16);
        end
        e.cyc = hc + 10;
        return e;
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp_valid_o}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_cycle",  cyc, mon_e.cyc);
                chk("rsp_id",     {31'd0, rsp_id_o}, {31'd0, mon_e.id});
                chk("rsp_err",    {31'd0, rsp_err_o}, {31'd0, mon_e.err});
                chk("rsp_x",      {24'd0, rsp_index_x_o}, {24'd0, mon_e.x});
                chk("rsp_y",      {24'd0, rsp_index_y_o}, {24'd0, mon_e.y});
                chk("rsp_strike", {31'd0, rsp_strike_o}, {31'd0, mon_e.strike});
            end
        end
    end

    task automatic send(input bit id, input logic [4:0] h, input logic [4:0] w, output int hcyc);
        bit done = 1'b0;
        hcyc = -1;
        @(negedge clk_i);
        if (id) begin req1_valid_i = 1'b1; req1_height_i = h; req1_width_i = w; end
        else    begin req0_valid_i = 1'b1; req0_height_i = h; req0_width_i = w; end
        #1;
        for (int i = 0; i < 40 && !done; i++) begin
            if ((id && req1_ready_o) || (!id && req0_ready_o)) begin
                hcyc = cyc;
                done = 1'b1;
                sb.push_back(mk_exp(id, h, w, hcyc));
                grant_q.push_back(id);
                hcyc_q.push_back(hcyc);
            end else begin
                @(negedge clk_i);
                #1;
            end
        end
        chk($sformatf("handshake_req%0d", id), {31'd0, done}, 1);
        @(posedge clk_i);
        #1;
        if (id) req1_valid_i = 1'b0;
        else    req0_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || busy_o) && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_queue", sb.size(), 0);
    endtask

    int h0, h1, ha, hb;
    bit exp_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_eng_h", {27'd0, eng_height_o}, 0);
        chk("rst_eng_w", {27'd0, eng_width_o}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_ready0", {31'd0, req0_ready_o}, 0);
        rst_i = 1'b0;
        rel_cyc = cyc;

        // 1: single request from reset
        send(1'b0, 5'd3, 5'd4, h0);
        chk("t1_hs_cycle", h0, rel_cyc + 3);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            chk("t1_eng_h", {27'd0, eng_height_o}, 3);
            chk("t1_eng_w", {27'd0, eng_width_o}, 4);
            chk("t1_busy", {31'd0, busy_o}, 1);
        end
        @(negedge clk_i);
        chk("t1_eng_idle_h", {27'd0, eng_height_o}, 0);
        chk("t1_eng_idle_w", {27'd0, eng_width_o}, 0);
        wait_drain();

        // 2: both requesters continuously valid; last grant was req0
        grant_q.delete();
        hcyc_q.delete();
        fork
            begin
                send(1'b0, 5'd3, 5'd4, ha);
                send(1'b0, 5'd20, 5'd7, ha);
                send(1'b0, 5'd9, 5'd9, ha);
            end
            begin
                send(1'b1, 5'd6, 5'd2, hb);
                send(1'b1, 5'd11, 5'd31, hb);
                send(1'b1, 5'd1, 5'd1, hb);
            end
        join
        chk("t2_grant_count", grant_q.size(), 6);
        for (int i = 0; i < 6 && i < grant_q.size(); i++) begin
            chk($sformatf("t2_grant_%0d", i), {31'd0, grant_q[i]}, {31'd0, exp_seq[i]});
            if (i > 0) chk($sformatf("t2_spacing_%0d", i), hcyc_q[i] - hcyc_q[i-1], 4);
        end
        wait_drain();

        // 3: zero-width request is consumed and answered with an error
        send(1'b1, 5'd5, 5'd0, h1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            chk("t3_eng_h", {27'd0, eng_height_o}, 0);
            chk("t3_eng_w", {27'd0, eng_width_o}, 0);
        end
        wait_drain();

        // 4: strike rises on the second request only
        send(1'b0, 5'd4, 5'd4, h0);
        send(1'b0, 5'd17, 5'd2, h0);
        send(1'b0, 5'd5, 5'd5, h0);
        wait_drain();

        // 5: asynchronous reset with two requests in flight
        send(1'b0, 5'd7, 5'd7, h0);
        send(1'b1, 5'd8, 5'd8, h1);
        @(negedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk("t5_eng_h", {27'd0, eng_height_o}, 0);
        chk("t5_eng_w", {27'd0, eng_width_o}, 0);
        chk("t5_rsp_valid", {31'd0, rsp_valid_o}, 0);
        chk("t5_rsp_x", {24'd0, rsp_index_x_o}, 0);
        chk("t5_rsp_y", {24'd0, rsp_index_y_o}, 0);
        chk("t5_busy", {31'd0, busy_o}, 0);
        sb.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        rel_cyc = cyc;
        repeat (12) @(negedge clk_i);
        rel_cyc = rel_cyc + 12;
        // both valid after reset: req0 wins because last grant resets to req1
        fork
            send(1'b0, 5'd2, 5'd3, ha);
            send(1'b1, 5'd3, 5'd2, hb);
        join
        chk("t5_hs0_cycle", ha, rel_cyc + 3);
        chk("t5_hs1_cycle", hb, rel_cyc + 7);
        wait_drain();

        // 6: valid dropped before the ready window is not a handshake
        while (((cyc - rel_cyc) % 4) != 0) @(negedge clk_i);
        req0_height_i = 5'd6;
        req0_width_i  = 5'd6;
        req0_valid_i  = 1'b1;
        #1;
        chk("t6_ready_s0", {31'd0, req0_ready_o}, 0);
        @(negedge clk_i);
        #1;
        chk("t6_ready_s1", {31'd0, req0_ready_o}, 0);
        @(negedge clk_i);
        req0_valid_i = 1'b0;
        for (int k = 0; k < 14; k++) begin
            #1;
            chk("t6_ready", {31'd0, req0_ready_o}, 0);
            chk("t6_eng_h", {27'd0, eng_height_o}, 0);
            chk("t6_busy", {31'd0, busy_o}, 0);
            @(negedge clk_i);
        end

        wait_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
